// File: rtl/seq_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen_if
// Control and serial-output bundle of the serial pattern generator.
//   master : the side that loads a job (start, pattern, len, reps, abort)
//            and watches the serial stream.
//   slave  : the generator itself.
// Signals:
//   start, abort           job request / cancel
//   pattern[PAT_W], len, reps  job description, captured on start
//   busy, done             job status
//   dout, dout_vld, frame_start  serial stream
// -----------------------------------------------------------------------------
interface seq_pattern_gen_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] reps;
  logic             abort;
  logic             busy;
  logic             dout;
  logic             dout_vld;
  logic             frame_start;
  logic             done;

  modport master (
    output start, pattern, len, reps, abort,
    input  busy, dout, dout_vld, frame_start, done
  );

  modport slave (
    input  start, pattern, len, reps, abort,
    output busy, dout, dout_vld, frame_start, done
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen
// Serial bit-pattern transmitter. A job (pattern, length, repeat count) is
// captured on start in IDLE and shifted out MSB-first, one bit per clock,
// with GAP idle cycles between frames. reps = 0 repeats until abort.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : seq_pattern_gen_if.slave
//          in : start, pattern, len, reps, abort
//          out: busy, dout, dout_vld, frame_start, done (all registered)
//
// Optional feature (macro SEQGEN_PARITY_EN): each frame is followed by one
// even-parity bit over the len transmitted bits.
// -----------------------------------------------------------------------------
module seq_pattern_gen #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int GAP   = 2
) (
  input  logic                clk,
  input  logic                rst,
  seq_pattern_gen_if.slave    bus
);

  localparam int CNT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_DONE
`ifdef SEQGEN_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  // State, counters and captured job. The state register always describes
  // what the registered outputs show in the current cycle.
  state_t           r_state;
  logic [CNT_W-1:0] r_bitcnt;
  logic [CNT_W-1:0] r_len_m1;
  logic [REP_W-1:0] r_repcnt;
  logic [GAP_W-1:0] r_gapcnt;
  logic [PAT_W-1:0] r_pattern;
  logic             r_busy;
  logic             r_dout;
  logic             r_dout_vld;
  logic             r_frame_start;
  logic             r_done;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_bitcnt_nxt;
  logic [CNT_W-1:0] w_len_m1_nxt;
  logic [REP_W-1:0] w_repcnt_nxt;
  logic [GAP_W-1:0] w_gapcnt_nxt;
  logic [PAT_W-1:0] w_pattern_nxt;
  logic [LEN_W-1:0] w_len_m1_raw;
  logic [CNT_W-1:0] w_len_eff_m1;
  logic             w_frame_end;
  logic             w_new_frame;
  logic             w_dout_nxt;
  logic             w_dout_vld_nxt;

`ifdef SEQGEN_PARITY_EN
  logic r_parity;
  logic w_parity_nxt;
  logic w_cap_parity;

  // Even parity over the bits that will actually be sent (indices 0..len-1).
  always_comb begin
    w_cap_parity = 1'b0;
    for (int i = 0; i < PAT_W; i++) begin
      if (i <= int'(w_len_eff_m1)) w_cap_parity = w_cap_parity ^ bus.pattern[i];
    end
  end

  assign w_frame_end = (r_state == S_PARITY);
`else
  assign w_frame_end = (r_state == S_SHIFT) && (r_bitcnt == '0);
`endif

  // Length 0 or anything beyond PAT_W means a full-width frame.
  always_comb begin
    w_len_m1_raw = bus.len - LEN_W'(1);
    if (bus.len == '0 || bus.len > LEN_W'(PAT_W)) w_len_eff_m1 = CNT_W'(PAT_W - 1);
    else                                            w_len_eff_m1 = w_len_m1_raw[CNT_W-1:0];
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the branches below can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_bitcnt_nxt  = r_bitcnt;
    w_len_m1_nxt  = r_len_m1;
    w_repcnt_nxt  = r_repcnt;
    w_gapcnt_nxt  = r_gapcnt;
    w_pattern_nxt = r_pattern;
`ifdef SEQGEN_PARITY_EN
    w_parity_nxt  = r_parity;
`endif
    w_new_frame   = 1'b0;

    if (r_state == S_IDLE) begin
      // abort wins over a simultaneous start
      if (bus.start && !bus.abort) begin
        w_state_nxt   = S_SHIFT;
        w_pattern_nxt = bus.pattern;
        w_len_m1_nxt  = w_len_eff_m1;
        w_bitcnt_nxt  = w_len_eff_m1;
        w_repcnt_nxt  = bus.reps;
`ifdef SEQGEN_PARITY_EN
        w_parity_nxt  = w_cap_parity;
`endif
        w_new_frame   = 1'b1;
      end
    end else if (bus.abort) begin
      w_state_nxt = S_IDLE;
    end else if (w_frame_end) begin
      // repcnt == 0 marks continuous mode: it is never decremented, and a
      // counted job leaves for DONE before its counter could reach 0 here.
      if (r_repcnt == REP_W'(1)) begin
        w_repcnt_nxt = '0;
        w_state_nxt  = S_DONE;
      end else begin
        if (r_repcnt != '0) w_repcnt_nxt = r_repcnt - REP_W'(1);
        if (GAP > 0) begin
          w_state_nxt  = S_GAP;
          w_gapcnt_nxt = GAP_W'(GAP_LOAD);
        end else begin
          w_state_nxt  = S_SHIFT;
          w_bitcnt_nxt = r_len_m1;
          w_new_frame  = 1'b1;
        end
      end
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (r_bitcnt != '0) w_bitcnt_nxt = r_bitcnt - CNT_W'(1);
`ifdef SEQGEN_PARITY_EN
          else                w_state_nxt  = S_PARITY;
`endif
        end
        S_GAP: begin
          if (r_gapcnt != '0) begin
            w_gapcnt_nxt = r_gapcnt - GAP_W'(1);
          end else begin
            w_state_nxt  = S_SHIFT;
            w_bitcnt_nxt = r_len_m1;
            w_new_frame  = 1'b1;
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // Outputs are derived from the next state so they register in step with it.
    w_dout_nxt     = 1'b0;
    w_dout_vld_nxt = 1'b0;
    if (w_state_nxt == S_SHIFT) begin
      w_dout_nxt     = w_pattern_nxt[w_bitcnt_nxt];
      w_dout_vld_nxt = 1'b1;
    end
`ifdef SEQGEN_PARITY_EN
    if (w_state_nxt == S_PARITY) begin
      w_dout_nxt     = w_parity_nxt;
      w_dout_vld_nxt = 1'b1;
    end
`endif
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_bitcnt      <= '0;
      r_len_m1      <= '0;
      r_repcnt      <= '0;
      r_gapcnt      <= '0;
      r_pattern     <= '0;
`ifdef SEQGEN_PARITY_EN
      r_parity      <= 1'b0;
`endif
      r_busy        <= 1'b0;
      r_dout        <= 1'b0;
      r_dout_vld    <= 1'b0;
      r_frame_start <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bitcnt      <= w_bitcnt_nxt;
      r_len_m1      <= w_len_m1_nxt;
      r_repcnt      <= w_repcnt_nxt;
      r_gapcnt      <= w_gapcnt_nxt;
      r_pattern     <= w_pattern_nxt;
`ifdef SEQGEN_PARITY_EN
      r_parity      <= w_parity_nxt;
`endif
      r_busy        <= (w_state_nxt != S_IDLE);
      r_dout        <= w_dout_nxt;
      r_dout_vld    <= w_dout_vld_nxt;
      r_frame_start <= w_new_frame;
      r_done        <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.busy        = r_busy;
  assign bus.dout        = r_dout;
  assign bus.dout_vld    = r_dout_vld;
  assign bus.frame_start = r_frame_start;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_gen
// Scoreboard bench for seq_pattern_gen. Each issued job is expanded by a
// frame-level model into the list of (cycle, bit, frame_start) events and the
// done pulse it must produce; a monitor pops one event whenever the DUT shows
// a valid bit or done, and also checks busy against the modelled busy window.
// -----------------------------------------------------------------------------
module tb_seq_pattern_gen;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int REP_W = 4;
  localparam int GAP   = 2;
`ifdef SEQGEN_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  typedef struct {
    int cyc;
    bit done;
    bit dout;
    bit fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   busy_from = 1;
  int   busy_to   = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  seq_pattern_gen_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .REP_W(REP_W)) bus ();

  seq_pattern_gen #(.PAT_W(PAT_W), .LEN_W(LEN_W), .REP_W(REP_W), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int eff_len(int len);
    return (len == 0 || len > PAT_W) ? PAT_W : len;
  endfunction

  // Frame-level model: frame f of a job accepted in cycle c starts at
  // c + 1 + f*(L+P+GAP); done follows the last frame. Events after an abort
  // cycle are dropped.
  function automatic void push_txn(int c, logic [PAT_W-1:0] pat, int len, int reps, int abort_off);
    int   L, t, f, lim, done_cyc;
    bit   par, finished;
    exp_t e;
    L   = eff_len(len);
    par = 1'b0;
    for (int i = 0; i < L; i++) par ^= pat[i];
    lim      = (abort_off >= 0) ? c + abort_off : 32'h3fff_ffff;
    t        = c + 1;
    f        = 0;
    finished = 1'b0;
    while (t <= lim) begin
      for (int k = 0; k < L + P; k++) begin
        if (t + k <= lim) begin
          e.cyc  = t + k;
          e.done = 1'b0;
          e.fs   = (k == 0);
          e.dout = (k < L) ? pat[L-1-k] : par;
          sb.push_back(e);
        end
      end
      f++;
      if (reps != 0 && f == reps) begin
        finished = 1'b1;
        break;
      end
      t += L + P + GAP;
    end
    done_cyc  = t + L + P;
    busy_from = c + 1;
    busy_to   = lim;
    if (finished && done_cyc <= lim) begin
      e.cyc  = done_cyc;
      e.done = 1'b1;
      e.dout = 1'b0;
      e.fs   = 1'b0;
      sb.push_back(e);
      busy_to = done_cyc;
    end
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", 32'(bus.busy), 32'(cyc >= busy_from && cyc <= busy_to));
      if (!bus.dout_vld) begin
        check("dout_idle", 32'(bus.dout), 0);
        check("fs_idle", 32'(bus.frame_start), 0);
      end
      if (bus.dout_vld || bus.done) begin
        if (sb.size() == 0) begin
          check("extra_output", 32'(bus.dout_vld | bus.done), 0);
        end else begin
          mon_e = sb.pop_front();
          check("out_cycle", cyc, mon_e.cyc);
          check("done", 32'(bus.done), 32'(mon_e.done));
          if (mon_e.done) begin
            check("vld_in_done", 32'(bus.dout_vld), 0);
          end else begin
            check("dout", 32'(bus.dout), 32'(mon_e.dout));
            check("frame_start", 32'(bus.frame_start), 32'(mon_e.fs));
          end
        end
      end
    end
  end

  // mode: 0 = start held low while busy, 1 = random start noise,
  //       2 = start held high with pattern 8'hFF while busy.
  task automatic issue(logic [PAT_W-1:0] pat, int len, int reps, int abort_off, int mode);
    int c;
    bus.pattern = pat;
    bus.len     = LEN_W'(len);
    bus.reps    = REP_W'(reps);
    bus.abort   = 1'b0;
    bus.start   = 1'b1;
    c = cyc;
    push_txn(c, pat, len, reps, abort_off);
    @(posedge clk); #1;
    while (cyc <= busy_to) begin
      bus.start   = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.pattern = (mode == 2) ? 8'hFF : PAT_W'($urandom);
      bus.len     = LEN_W'($urandom);
      bus.reps    = REP_W'($urandom);
      bus.abort   = (abort_off >= 0 && cyc == c + abort_off);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int pat, len, reps, aoff, L, dofs, c;

    // Reset held with start pulsing: everything stays quiet.
    rst         = 1'b1;
    bus.start   = 1'b1;
    bus.abort   = 1'b0;
    bus.pattern = 8'h06;
    bus.len     = 4'd4;
    bus.reps    = 4'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_dout", 32'(bus.dout), 0);
    check("rst_vld", 32'(bus.dout_vld), 0);
    check("rst_fs", 32'(bus.frame_start), 0);
    check("rst_done", 32'(bus.done), 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    rst       = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Directed jobs
    issue(8'h06, 4, 1, -1, 0);   // single frame 0110
    issue(8'h06, 4, 3, -1, 1);   // three frames with gaps
    issue(8'h06, 4, 0, 10, 0);   // continuous, aborted in cycle 10
    issue(8'hA5, 0, 1, -1, 2);   // length clamp, restart attempts with 8'hFF
    issue(8'h3C, 9, 2, -1, 1);   // length above PAT_W clamps too
    issue(8'h01, 1, 3, -1, 1);   // one-bit frames

    // Asynchronous reset while bit 2 of a frame is on the line.
    bus.pattern = 8'hC3;
    bus.len     = 4'd0;
    bus.reps    = 4'd1;
    bus.start   = 1'b1;
    c = cyc;
    push_txn(c, 8'hC3, 0, 1, 2);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #1;
    rst     = 1'b1;
    busy_to = 0;
    #1;
    check("rstmid_vld", 32'(bus.dout_vld), 0);
    check("rstmid_busy", 32'(bus.busy), 0);
    check("rstmid_done", 32'(bus.done), 0);
    check("rstmid_dout", 32'(bus.dout), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("sb_drained", sb.size(), 0);

    // Randomized jobs
    for (int n = 0; n < 20; n++) begin
      pat  = int'($urandom_range(0, 255));
      len  = int'($urandom_range(0, 15));
      reps = int'($urandom_range(0, 3));
      L    = eff_len(len);
      dofs = reps * (L + P) + (reps - 1) * GAP + 1;
      if (reps == 0)                       aoff = int'($urandom_range(2, 30));
      else if ($urandom_range(0, 3) == 0)  aoff = int'($urandom_range(1, dofs));
      else                                 aoff = -1;
      issue(PAT_W'(pat), len, reps, aoff, 1);
    end

    check("sb_final", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial bit-pattern transmitter; the generating end of the serial sequence-detector interface.
- Software or a bench loads a pattern of up to PAT_W bits, a length and a repeat count.
- Shifts the pattern out one bit per clock, MSB-first, with optional idle gaps between repetitions.
- Output `dout` drives directly into a sequence detector's serial data input, e.g. pattern 0110 for the 0110 detector.

Parameters:
- PAT_W, 8: maximum pattern length in bits.
- LEN_W, 4: width of `len`; must hold PAT_W.
- REP_W, 4: width of the repeat count.
- GAP, 2: idle cycles inserted between repetitions; 0 means back-to-back.

Ports:
- clk  in  1: clock, rising edge.
- rst  in  1: reset, asynchronous, active-high.
- start  in  1: request to begin a transmission; sampled only in IDLE.
- pattern  in  PAT_W: bits to send; bit len-1 is sent first, bit 0 last.
- len  in  LEN_W: number of bits per frame; 0 or >PAT_W is treated as PAT_W.
- reps  in  REP_W: number of frames to send; 0 means continuous until abort.
- abort  in  1: stop the current transmission.
- busy  out  1: high from the cycle after start is accepted through the DONE state.
- dout  out  1: serial data; 0 whenever dout_vld=0.
- dout_vld  out  1: dout carries a pattern bit this cycle.
- frame_start  out  1: high on the first bit of each frame.
- done  out  1: one-cycle pulse after the final frame completes.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy, dout, dout_vld, frame_start and done are all 0.
  - Captured registers are cleared.
- All outputs are registered.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE, start=1, abort=0:
  - Capture pattern, effective len and reps.
  - Bit counter is set to len-1; repetition counter is set to reps.
  - Go to SHIFT.
  - The first bit appears on dout with dout_vld=1 and frame_start=1 in the next cycle (1-cycle latency).
- SHIFT:
  - Each cycle, dout = pattern[bitcnt] and dout_vld=1; the bit counter decrements.
  - On the last bit (bitcnt=0):
    - Decrement the repetition counter, unless in continuous mode.
    - If more frames remain: go to GAP when GAP>0, otherwise stay in SHIFT, reload bitcnt=len-1 and assert frame_start on the next bit.
    - If no frames remain: go to DONE.
- GAP:
  - Lasts exactly GAP cycles with dout=0 and dout_vld=0.
  - Then return to SHIFT with bitcnt reloaded.
- DONE:
  - Lasts one cycle; done=1, busy=1, dout_vld=0.
  - Then go to IDLE, where busy=0 in the following cycle.
- Continuous mode (reps=0): frames repeat indefinitely, never entering DONE.
- abort:
  - Highest priority after reset, in any non-IDLE state.
  - Next cycle: state is IDLE, dout_vld=0, busy=0, no done pulse.
  - abort in IDLE has no effect. If start and abort are both high in IDLE, start is ignored.
- start while busy is ignored; captured inputs are not disturbed.
- Changes to pattern, len or reps after capture have no effect on the transmission in progress.
- Asserting rst mid-frame terminates immediately (async); no done pulse is produced.
- Counters never wrap:
  - The bit counter is reloaded, never decremented below 0.
  - The repetition counter saturates at 0 in continuous mode.

Optional Feature:
- Macro: SEQGEN_PARITY_EN.
- Defined:
  - After the last pattern bit of every frame, one extra bit with dout_vld=1 is sent.
  - Its value is the XOR of the len transmitted bits (even parity).
  - Frame length becomes len+1; the gap or DONE follows the parity bit.
- Undefined: frames are exactly len bits; no parity logic is synthesized.

Test Plan:
- Reset: hold rst=1 with start pulsed -> all outputs 0, busy stays 0. Assert rst during bit 2 of a frame -> dout_vld=0 immediately, no done, returns to IDLE.
- Single frame: pattern=8'b0000_0110, len=4, reps=1, start at cycle 0 ->
  - dout 0,1,1,0 on cycles 1-4, with dout_vld=1 on those cycles;
  - frame_start at cycle 1 only;
  - done at cycle 5; busy high for cycles 1-5.
- Repeats with gap: same pattern, reps=3, GAP=2 ->
  - frames on cycles 1-4, 7-10 and 13-16;
  - dout_vld=0 on cycles 5-6 and 11-12;
  - frame_start on cycles 1, 7 and 13;
  - done at cycle 17.
- Continuous and abort: reps=0, len=4; abort at cycle 10 ->
  - bits repeat 0110 without a gap when GAP=0;
  - dout_vld=0 and busy=0 from cycle 11;
  - done never asserted.
- Length clamp and busy guard:
  - len=0 with pattern=8'hA5 -> 1,0,1,0,0,1,0,1 over 8 cycles.
  - A second start mid-frame with pattern=8'hFF -> ignored; the output still follows 8'hA5.
- Parity (macro defined): pattern 0110, len=4 -> 0,1,1,0 then parity 0; pattern 0111, len=4 -> 0,1,1,1 then parity 1. done is one cycle later than without the macro.
